// File: rtl/shift_pkg.sv
// Shared definitions for the 8-bit shift/rotate unit and its sequential inverter:
// operation codes, data widths and the inverter FSM state encoding.
package shift_pkg;

  localparam int WIDTH = 8;
  localparam int AMT_W = 3;

  typedef logic [2:0] shift_code_t;

  localparam shift_code_t SH_LSR = 3'b000;
  localparam shift_code_t SH_LSL = 3'b001;
  localparam shift_code_t SH_ASR = 3'b010;
  localparam shift_code_t SH_ASL = 3'b011;
  localparam shift_code_t SH_ROR = 3'b100;
  localparam shift_code_t SH_ROL = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Codes 11x have no forward operation and therefore no inverse.
  function automatic logic code_supported(input shift_code_t code);
    return code[2:1] != 2'b11;
  endfunction

endpackage

// File: rtl/shift_inverter8_if.sv
// Request/response bundle of the shift inverter: valid/ready on the request side
// (shifted word, code, amount) and on the result side (recovered operand, error).
interface shift_inverter8_if;
  import shift_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  NumY;
  shift_code_t       ShiftType;
  logic [AMT_W-1:0]  ShiftAmt;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  OutA;
  logic              OutErr;

  modport master (
    output in_valid, NumY, ShiftType, ShiftAmt, out_ready,
    input  in_ready, out_valid, OutA, OutErr
  );

  modport slave (
    input  in_valid, NumY, ShiftType, ShiftAmt, out_ready,
    output in_ready, out_valid, OutA, OutErr
  );

endinterface

// File: rtl/shift_inverter8_unshift_step.sv
// One inverse step of a forward shift/rotate by one position, plus a flag telling
// whether the current word could have come out of that forward step.
module unshift_step
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0] i_word,
  input  shift_code_t      i_code,
  output logic [WIDTH-1:0] o_word,
  output logic             o_step_err
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves
    // it unassigned, which would otherwise infer a latch.
    o_word     = i_word;
    o_step_err = 1'b0;
    case (i_code)
      SH_LSR: begin
        o_word     = {i_word[WIDTH-2:0], 1'b0};
        o_step_err = i_word[WIDTH-1];
      end
      SH_ASR: begin
        o_word     = {i_word[WIDTH-2:0], 1'b0};
        o_step_err = i_word[WIDTH-1] ^ i_word[WIDTH-2];
      end
      SH_LSL, SH_ASL: begin
        o_word     = {1'b0, i_word[WIDTH-1:1]};
        o_step_err = i_word[0];
      end
      SH_ROR: o_word = {i_word[WIDTH-2:0], i_word[WIDTH-1]};
      SH_ROL: o_word = {i_word[0], i_word[WIDTH-1:1]};
      default: o_step_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_inverter8.sv
// Sequential inverter of the 8-bit shift/rotate unit: recovers the pre-shift
// operand one bit position per cycle and flags inputs the forward op cannot produce.
module shift_inverter8
  import shift_pkg::*;
(
  input logic               clk,
  input logic               rst,
  shift_inverter8_if.slave  bus
);

  localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

  state_e            r_state;
  logic [WIDTH-1:0]  r_work;
  logic              r_err;
  logic [AMT_W-1:0]  r_cnt;
  shift_code_t       r_type;

  state_e            w_state_nxt;
  logic [WIDTH-1:0]  w_work_nxt;
  logic              w_err_nxt;
  logic [AMT_W-1:0]  w_cnt_nxt;
  shift_code_t       w_type_nxt;
  logic [WIDTH-1:0]  w_step_word;
  logic              w_step_err;

  unshift_step u_step (
    .i_word     (r_work),
    .i_code     (r_type),
    .o_word     (w_step_word),
    .o_step_err (w_step_err)
  );

  assign bus.in_ready  = (r_state == ST_IDLE) && !rst;
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.OutA      = r_work;
  assign bus.OutErr    = r_err;

  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;
    w_type_nxt  = r_type;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          w_work_nxt = bus.NumY;
          w_type_nxt = bus.ShiftType;
          w_cnt_nxt  = bus.ShiftAmt;
          w_err_nxt  = 1'b0;
          if (!code_supported(bus.ShiftType)) begin
            w_err_nxt   = 1'b1;
            w_work_nxt  = '0;
            w_state_nxt = ST_DONE;
          end else if (bus.ShiftAmt == '0) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_STEP;
          end
        end
      end
      ST_STEP: begin
        // The check looks at the word before this step, and errors stay sticky.
        w_work_nxt = w_step_word;
        w_err_nxt  = r_err | w_step_err;
        w_cnt_nxt  = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_work  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_type  <= SH_LSR;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
      r_type  <= w_type_nxt;
    end
  end

endmodule

// File: tb/tb_shift_inverter8.sv
// Self-checking bench for shift_inverter8: directed cases, backpressure, reset
// during a run and randomized requests against an arithmetic reference model.
module tb_shift_inverter8;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  shift_inverter8_if bus();

  shift_inverter8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the whole inversion in one go, {err, operand}.
  function automatic logic [8:0] model(input logic [7:0] y, input logic [2:0] code,
                                       input logic [2:0] amt);
    int yi;
    int n;
    int a;
    int top;
    bit err;
    yi  = int'(y);
    n   = int'(amt);
    a   = 0;
    err = 1'b0;
    case (code)
      SH_LSR: begin
        a   = (yi << n) & 255;
        err = (yi >> (8 - n)) != 0;
      end
      SH_LSL, SH_ASL: begin
        a   = yi >> n;
        err = (yi & ((1 << n) - 1)) != 0;
      end
      SH_ASR: begin
        a   = (yi << n) & 255;
        top = yi >> (7 - n);
        err = !(top == 0 || top == (1 << (n + 1)) - 1);
      end
      SH_ROR: a = ((yi << n) | (yi >> (8 - n))) & 255;
      SH_ROL: a = ((yi >> n) | (yi << (8 - n))) & 255;
      default: begin
        a   = 0;
        err = 1'b1;
      end
    endcase
    return {err, 8'(a)};
  endfunction

  function automatic int model_lat(input logic [2:0] code, input logic [2:0] amt);
    if (!code_supported(code) || amt == 3'd0) return 1;
    return int'(amt) + 1;
  endfunction

  // Compare process: tracks the one request in flight and checks every cycle.
  bit          mon_busy = 1'b0;
  bit          mon_post_rst = 1'b0;
  int          mon_cyc;
  int          mon_lat;
  logic [8:0]  mon_exp;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_post_rst) begin
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_OutA", 32'(bus.OutA), 32'd0);
        check("rst_OutErr", 32'(bus.OutErr), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'(!rst));
        mon_post_rst = 1'b0;
      end
      if (rst) begin
        mon_busy     = 1'b0;
        mon_post_rst = 1'b1;
      end else if (mon_busy) begin
        mon_cyc++;
        check("mon_in_ready_busy", 32'(bus.in_ready), 32'd0);
        if (mon_cyc < mon_lat) begin
          check("mon_early_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          check("mon_out_valid", 32'(bus.out_valid), 32'd1);
          check("mon_OutA", 32'(bus.OutA), 32'(mon_exp[7:0]));
          check("mon_OutErr", 32'(bus.OutErr), 32'(mon_exp[8]));
          if (bus.out_valid && bus.out_ready) mon_busy = 1'b0;
        end
      end else begin
        check("mon_idle_ready", 32'(bus.in_ready), 32'd1);
        check("mon_idle_valid", 32'(bus.out_valid), 32'd0);
        if (bus.in_valid && bus.in_ready) begin
          mon_exp  = model(bus.NumY, bus.ShiftType, bus.ShiftAmt);
          mon_lat  = model_lat(bus.ShiftType, bus.ShiftAmt);
          mon_cyc  = 0;
          mon_busy = 1'b1;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [7:0] y, input logic [2:0] code, input logic [2:0] amt);
    bit ok;
    ok            = 1'b0;
    bus.in_valid  = 1'b1;
    bus.NumY      = y;
    bus.ShiftType = code;
    bus.ShiftAmt  = amt;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk) #1;
  endtask

  // Waits for the result, holds out_ready low for bp extra cycles, then completes
  // the handshake; returns at posedge+1 after the handshake edge.
  task automatic collect(input int bp, output int lat, output logic [7:0] a, output logic e);
    bit got;
    got           = 1'b0;
    lat           = 0;
    a             = '0;
    e             = 1'b0;
    bus.out_ready = (bp == 0);
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) got = 1'b1;
    end
    if (!got) begin
      check("result_timeout", 32'd0, 32'd1);
      bus.out_ready = 1'b1;
    end else begin
      a = bus.OutA;
      e = bus.OutErr;
      if (bp > 0) begin
        repeat (bp) @(negedge clk);
        check("bp_hold_OutA", 32'(bus.OutA), 32'(a));
        check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk) #1;
        bus.out_ready = 1'b1;
      end
      @(posedge clk) #1;
    end
  endtask

  task automatic run(input string name, input logic [7:0] y, input logic [2:0] code,
                     input logic [2:0] amt, input logic [7:0] exp_a, input logic exp_e,
                     input int exp_lat);
    logic [8:0] m;
    int         lat;
    logic [7:0] a;
    logic       e;
    m = model(y, code, amt);
    check({name, "_model_a"}, 32'(m[7:0]), 32'(exp_a));
    check({name, "_model_err"}, 32'(m[8]), 32'(exp_e));
    send(y, code, amt);
    bus.in_valid = 1'b0;
    collect(0, lat, a, e);
    check({name, "_OutA"}, 32'(a), 32'(exp_a));
    check({name, "_OutErr"}, 32'(e), 32'(exp_e));
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int         lat;
    logic [7:0] a;
    logic       e;
    logic [7:0] ry;
    logic [2:0] rc;
    logic [2:0] ra;
    int         bp;

    bus.in_valid  = 1'b0;
    bus.NumY      = '0;
    bus.ShiftType = '0;
    bus.ShiftAmt  = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk) #1;

    run("lsr",      8'h16, SH_LSR, 3'd3, 8'hB0, 1'b0, 4);
    run("ror",      8'h76, SH_ROR, 3'd3, 8'hB3, 1'b0, 4);
    run("rol",      8'h9D, SH_ROL, 3'd3, 8'hB3, 1'b0, 4);
    run("lsl_err",  8'h81, SH_LSL, 3'd3, 8'h10, 1'b1, 4);
    run("asr",      8'hF6, SH_ASR, 3'd3, 8'hB0, 1'b0, 4);
    run("asr_err",  8'hA6, SH_ASR, 3'd3, 8'h30, 1'b1, 4);
    run("asl_amt0", 8'h5A, SH_ASL, 3'd0, 8'h5A, 1'b0, 1);
    run("unsup110", 8'h37, 3'b110, 3'd5, 8'h00, 1'b1, 1);
    run("unsup111", 8'hFF, 3'b111, 3'd0, 8'h00, 1'b1, 1);
    run("rol_amt7", 8'h01, SH_ROL, 3'd7, 8'h02, 1'b0, 8);

    // Backpressure with a second request waiting on in_valid the whole time.
    send(8'h16, SH_LSR, 3'd3);
    bus.NumY      = 8'h9D;
    bus.ShiftType = SH_ROL;
    bus.ShiftAmt  = 3'd3;
    collect(5, lat, a, e);
    check("bp_OutA", 32'(a), 32'hB0);
    check("bp_OutErr", 32'(e), 32'd0);
    check("bp_latency", 32'(lat), 32'd4);
    @(negedge clk);
    check("bp_ready_after", 32'(bus.in_ready), 32'd1);
    check("bp_valid_after", 32'(bus.out_valid), 32'd0);
    @(posedge clk) #1;
    bus.in_valid = 1'b0;
    collect(0, lat, a, e);
    check("bp2_OutA", 32'(a), 32'hB3);
    check("bp2_OutErr", 32'(e), 32'd0);
    check("bp2_latency", 32'(lat), 32'd4);

    // Reset in the middle of a long run.
    send(8'h9D, SH_ROL, 3'd7);
    bus.in_valid = 1'b0;
    @(posedge clk) #1;
    rst = 1'b1;
    @(posedge clk) #1;
    @(negedge clk);
    check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_OutA", 32'(bus.OutA), 32'd0);
    check("rst_mid_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk) #1;
    run("post_rst", 8'h9D, SH_ROL, 3'd3, 8'hB3, 1'b0, 4);

    for (int i = 0; i < 150; i++) begin
      ry = 8'($urandom_range(0, 255));
      rc = 3'($urandom_range(0, 7));
      ra = 3'($urandom_range(0, 7));
      bp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(ry, rc, ra);
      bus.in_valid = 1'b0;
      collect(bp, lat, a, e);
      check("rand_latency", 32'(lat), 32'(model_lat(rc, ra)));
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
